// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with flush, optional output skid buffer and occupancy count
module pipe_stage_chain #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1,
    parameter int SKID     = 0,
    parameter int CLR_DATA = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(DEPTH+SKID+1)-1:0]    count
);
    localparam int CW = $clog2(DEPTH + SKID + 1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
    logic                         sv_q, sv_d;
    logic [WIDTH-1:0]             sd_q, sd_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH:0]               rdy, src_v;
    logic [DEPTH:0][WIDTH-1:0]    src_d;
    logic                         skid_load;

    // Ready ripples back from the output so a full chain still advances every cycle; with a skid
    // buffer the output end depends only on the skid register, cutting the out_ready -> in_ready path.
    always_comb begin
        rdy[DEPTH] = (SKID != 0) ? ~sv_q : out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
        in_ready  = rdy[0] & ~flush;
        out_valid = (sv_q | v_q[DEPTH-1]) & ~flush;
        out_data  = sv_q ? sd_q : d_q[DEPTH-1];
        src_v     = {v_q, in_valid};
        src_d     = {d_q, in_data};
    end

    // Next state: each ready stage takes its upstream entry; data moves only with a valid entry so
    // bubbles keep old contents; flush wins over every load.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = flush ? 1'b0 : (rdy[k] ? src_v[k] : v_q[k]);
            d_d[k] = flush ? ((CLR_DATA != 0) ? '0 : d_q[k])
                           : ((rdy[k] & src_v[k]) ? src_d[k] : d_q[k]);
        end
        skid_load = (SKID != 0) && !sv_q && v_q[DEPTH-1] && !out_ready;
        sv_d      = ~flush & (skid_load | ((SKID != 0) & sv_q & ~out_ready));
        sd_d      = flush ? ((CLR_DATA != 0) ? '0 : sd_q) : (skid_load ? d_q[DEPTH-1] : sd_q);
        count_d   = CW'(sv_d);
        for (int k = 0; k < DEPTH; k++) count_d = count_d + CW'(v_d[k]);
    end

    // Valid bits and occupancy clear asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q     <= '0;
            sv_q    <= 1'b0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            sv_q    <= sv_d;
            count_q <= count_d;
        end
    end

    generate
        if (CLR_DATA != 0) begin : g_clr
            // Data registers zeroed on reset
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    d_q  <= '0;
                    sd_q <= '0;
                end else begin
                    d_q  <= d_d;
                    sd_q <= sd_d;
                end
            end
        end else begin : g_keep
            // Data registers carry no reset
            always_ff @(posedge clk) begin
                d_q  <= d_d;
                sd_q <= sd_d;
            end
        end
    endgenerate

    assign count = count_q;
endmodule
